// File: rtl/operand_fetch.sv
// operand_fetch: two-slot read sequencer for a 1-cycle synchronous register file, with writeback forwarding.
// Optional feature macro OPF_PERF_EN adds a saturating stall_cnt output.
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            reset,
    // Handshakes: a transfer happens on a cycle where valid && ready; ready never depends on valid,
    // and a producer holds valid and payload stable until the transfer.
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_rs1,
    input  logic [AW-1:0]   req_rs2,
    input  logic [TAGW-1:0] req_tag,
    output logic [AW-1:0]   rf_rs1,
    output logic [AW-1:0]   rf_rs2,
    input  logic [XLEN-1:0] rf_rv1,
    input  logic [XLEN-1:0] rf_rv2,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_wd,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [XLEN-1:0] op_rs1_val,
    output logic [XLEN-1:0] op_rs2_val,
    output logic [TAGW-1:0] op_tag
`ifdef OPF_PERF_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    // S1: read in flight
    logic            s1_valid_q, s1_valid_d;
    logic [AW-1:0]   s1_rs1_q, s1_rs1_d;
    logic [AW-1:0]   s1_rs2_q, s1_rs2_d;
    logic [TAGW-1:0] s1_tag_q, s1_tag_d;

    // S2: output register, keeps its source indices for late forwarding
    logic            op_valid_q, op_valid_d;
    logic [XLEN-1:0] op_rs1_val_q, op_rs1_val_d;
    logic [XLEN-1:0] op_rs2_val_q, op_rs2_val_d;
    logic [TAGW-1:0] op_tag_q, op_tag_d;
    logic [AW-1:0]   s2_rs1_q, s2_rs1_d;
    logic [AW-1:0]   s2_rs2_q, s2_rs2_d;

    logic            wb_we_q;
    logic [AW-1:0]   wb_rd_q;
    logic [XLEN-1:0] wb_wd_q;

    logic            s2_free;
    logic            req_fire;
    logic            s1_move;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // The file's registered read lags one cycle, so last cycle's write is covered by wb_q.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [AW-1:0]   rs,
        input logic [XLEN-1:0] rv,
        input logic            we,
        input logic [AW-1:0]   rd,
        input logic [XLEN-1:0] wd,
        input logic            we_q,
        input logic [AW-1:0]   rd_q,
        input logic [XLEN-1:0] wd_q
    );
        logic [XLEN-1:0] res;
        if (rs == '0)
            res = '0;
        else if (we && rd == rs)
            res = wd;
        else if (we_q && rd_q == rs)
            res = wd_q;
        else
            res = rv;
        return res;
    endfunction

    assign s2_free   = !op_valid_q || op_ready;
    assign req_ready = !s1_valid_q || s2_free;
    assign req_fire  = req_valid && req_ready;
    assign s1_move   = s1_valid_q && s2_free;

    assign rf_rs1 = req_fire ? req_rs1 : s1_rs1_q;
    assign rf_rs2 = req_fire ? req_rs2 : s1_rs2_q;

    assign fwd_rs1 = fwd_sel(s1_rs1_q, rf_rv1, wb_we, wb_rd, wb_wd, wb_we_q, wb_rd_q, wb_wd_q);
    assign fwd_rs2 = fwd_sel(s1_rs2_q, rf_rv2, wb_we, wb_rd, wb_wd, wb_we_q, wb_rd_q, wb_wd_q);

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_rs1_d     = s1_rs1_q;
        s1_rs2_d     = s1_rs2_q;
        s1_tag_d     = s1_tag_q;
        op_valid_d   = op_valid_q;
        op_rs1_val_d = op_rs1_val_q;
        op_rs2_val_d = op_rs2_val_q;
        op_tag_d     = op_tag_q;
        s2_rs1_d     = s2_rs1_q;
        s2_rs2_d     = s2_rs2_q;

        if (req_fire) begin
            s1_valid_d = 1'b1;
            s1_rs1_d   = req_rs1;
            s1_rs2_d   = req_rs2;
            s1_tag_d   = req_tag;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end

        if (s1_move) begin
            op_valid_d   = 1'b1;
            op_rs1_val_d = fwd_rs1;
            op_rs2_val_d = fwd_rs2;
            op_tag_d     = s1_tag_q;
            s2_rs1_d     = s1_rs1_q;
            s2_rs2_d     = s1_rs2_q;
        end else if (op_ready) begin
            op_valid_d = 1'b0;
        end else if (op_valid_q) begin
            // Held pair: a writeback to one of its sources must not leave it stale.
            if (wb_we && wb_rd == s2_rs1_q && s2_rs1_q != '0)
                op_rs1_val_d = wb_wd;
            if (wb_we && wb_rd == s2_rs2_q && s2_rs2_q != '0)
                op_rs2_val_d = wb_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_rs1_q     <= '0;
            s1_rs2_q     <= '0;
            s1_tag_q     <= '0;
            op_valid_q   <= 1'b0;
            op_rs1_val_q <= '0;
            op_rs2_val_q <= '0;
            op_tag_q     <= '0;
            s2_rs1_q     <= '0;
            s2_rs2_q     <= '0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_wd_q      <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_rs1_q     <= s1_rs1_d;
            s1_rs2_q     <= s1_rs2_d;
            s1_tag_q     <= s1_tag_d;
            op_valid_q   <= op_valid_d;
            op_rs1_val_q <= op_rs1_val_d;
            op_rs2_val_q <= op_rs2_val_d;
            op_tag_q     <= op_tag_d;
            s2_rs1_q     <= s2_rs1_d;
            s2_rs2_q     <= s2_rs2_d;
            wb_we_q      <= wb_we;
            wb_rd_q      <= wb_rd;
            wb_wd_q      <= wb_wd;
        end
    end

    assign op_valid   = op_valid_q;
    assign op_rs1_val = op_rs1_val_q;
    assign op_rs2_val = op_rs2_val_q;
    assign op_tag     = op_tag_q;

`ifdef OPF_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (op_valid_q && !op_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed bench for operand_fetch with a behavioural 1-cycle register file.
// Build with OPF_PERF_EN defined to also exercise stall_cnt.
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [3:0]  req_tag;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [31:0] rf_rv1;
    logic [31:0] rf_rv2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_rs1_val;
    logic [31:0] op_rs2_val;
    logic [3:0]  op_tag;
`ifdef OPF_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int checks;
    int failures;

    operand_fetch #(.XLEN(32), .AW(5), .TAGW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_tag    (req_tag),
        .rf_rs1     (rf_rs1),
        .rf_rs2     (rf_rs2),
        .rf_rv1     (rf_rv1),
        .rf_rv2     (rf_rv2),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_wd      (wb_wd),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_rs1_val (op_rs1_val),
        .op_rs2_val (op_rs2_val),
        .op_tag     (op_tag)
`ifdef OPF_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: synchronous read returns the pre-write value, x0 reads 0.
    logic [31:0] rf_mem [32];
    always_ff @(posedge clk) begin
        if (wb_we && wb_rd != 5'd0)
            rf_mem[wb_rd] <= wb_wd;
        rf_rv1 <= (rf_rs1 == 5'd0) ? 32'd0 : rf_mem[rf_rs1];
        rf_rv2 <= (rf_rs2 == 5'd0) ? 32'd0 : rf_mem[rf_rs2];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  tag;
        int          wb_when;  // 0 none, 1 with the request, 2 one cycle later
        logic [4:0]  wb_rd;
        logic [31:0] wb_wd;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs[12];
    logic [67:0] exp_q[$];

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] wd);
        wb_we = 1'b1;
        wb_rd = rd;
        wb_wd = wd;
        step();
        wb_we = 1'b0;
    endtask

    task automatic drive_req(input logic [4:0] rs1, input logic [4:0] rs2, input logic [3:0] tag);
        req_valid = 1'b1;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_tag   = tag;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        op_ready = 1'b1;
        drive_req(v.rs1, v.rs2, v.tag);
        if (v.wb_when == 1) begin
            wb_we = 1'b1; wb_rd = v.wb_rd; wb_wd = v.wb_wd;
        end
        check1($sformatf("vec%0d_req_ready", idx), req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        wb_we = 1'b0;
        if (v.wb_when == 2) begin
            wb_we = 1'b1; wb_rd = v.wb_rd; wb_wd = v.wb_wd;
        end
        check1($sformatf("vec%0d_early_valid", idx), op_valid, 1'b0);
        step();
        wb_we = 1'b0;
        check1($sformatf("vec%0d_op_valid", idx), op_valid, 1'b1);
        check32($sformatf("vec%0d_rs1_val", idx), op_rs1_val, v.exp1);
        check32($sformatf("vec%0d_rs2_val", idx), op_rs2_val, v.exp2);
        check32($sformatf("vec%0d_tag", idx), {28'd0, op_tag}, {28'd0, v.tag});
        step();
        check1($sformatf("vec%0d_popped", idx), op_valid, 1'b0);
    endtask

    initial begin
        logic [67:0] e;
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_tag   = '0;
        wb_we     = 1'b0;
        wb_rd     = '0;
        wb_wd     = '0;
        op_ready  = 1'b1;

        // Preload x1..x31 = 0xA000_00nn, then the named test registers (hand-computed table below)
        vecs[0]  = '{5'd5,  5'd6,  4'd3,  0, 5'd0,  32'h0,    32'h11,        32'h22};
        vecs[1]  = '{5'd6,  5'd5,  4'd1,  0, 5'd0,  32'h0,    32'h22,        32'h11};
        vecs[2]  = '{5'd0,  5'd5,  4'd2,  0, 5'd0,  32'h0,    32'h0,         32'h11};
        vecs[3]  = '{5'd10, 5'd10, 4'd4,  0, 5'd0,  32'h0,    32'hA000_000A, 32'hA000_000A};
        vecs[4]  = '{5'd31, 5'd1,  4'd15, 0, 5'd0,  32'h0,    32'hA000_001F, 32'hA000_0001};
        vecs[5]  = '{5'd7,  5'd6,  4'd5,  1, 5'd7,  32'hABCD, 32'hABCD,      32'h22};
        vecs[6]  = '{5'd6,  5'd7,  4'd6,  2, 5'd7,  32'hBEEF, 32'h22,        32'hBEEF};
        vecs[7]  = '{5'd12, 5'd12, 4'd9,  2, 5'd12, 32'h1234, 32'h1234,      32'h1234};
        vecs[8]  = '{5'd0,  5'd0,  4'd0,  1, 5'd0,  32'hFFFF, 32'h0,         32'h0};
        vecs[9]  = '{5'd0,  5'd3,  4'd10, 2, 5'd0,  32'hFFFF, 32'h0,         32'hA000_0003};
        vecs[10] = '{5'd5,  5'd6,  4'd11, 2, 5'd8,  32'h7777, 32'h11,        32'h22};
        vecs[11] = '{5'd7,  5'd8,  4'd12, 0, 5'd0,  32'h0,    32'hBEEF,      32'h7777};

        // Reset for two cycles
        step();
        step();
        reset = 1'b0;
        check1("reset_op_valid", op_valid, 1'b0);
        check32("reset_rs1_val", op_rs1_val, 32'h0);
        check32("reset_rs2_val", op_rs2_val, 32'h0);
        check32("reset_tag", {28'd0, op_tag}, 32'h0);
        check1("reset_req_ready", req_ready, 1'b1);

        for (int i = 1; i < 32; i++)
            wb_write(5'(i), 32'hA000_0000 | 32'(i));
        wb_write(5'd5, 32'h11);
        wb_write(5'd6, 32'h22);
        wb_write(5'd7, 32'h1);
        wb_write(5'd9, 32'h9);

`ifdef OPF_PERF_EN
        check32("stall_cnt_init", stall_cnt, 32'd0);
        op_ready = 1'b0;
        drive_req(5'd5, 5'd6, 4'd1);
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check1("perf_held", op_valid, 1'b1);
            step();
        end
        check32("stall_cnt_5", stall_cnt, 32'd5);
        op_ready = 1'b1;
        step();
        check32("stall_cnt_after_pop", stall_cnt, 32'd5);
        check1("perf_popped", op_valid, 1'b0);
`endif

        for (int i = 0; i < 12; i++)
            apply_vec(i, vecs[i]);

        // Throughput: 8 back-to-back requests, ops on 8 consecutive cycles in order
        op_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                drive_req(5'(16 + c), 5'(24 + c), 4'(c));
                exp_q.push_back({4'(c), 32'hA000_0000 | 32'(16 + c), 32'hA000_0000 | 32'(24 + c)});
                check1("tp_req_ready", req_ready, 1'b1);
            end else begin
                req_valid = 1'b0;
            end
            if (c >= 2 && c < 10) begin
                check1("tp_op_valid", op_valid, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check32("tp_tag", {28'd0, op_tag}, {28'd0, e[67:64]});
                    check32("tp_rs1_val", op_rs1_val, e[63:32]);
                    check32("tp_rs2_val", op_rs2_val, e[31:0]);
                end else begin
                    check1("tp_queue_empty", 1'b1, 1'b0);
                end
            end else begin
                check1("tp_idle", op_valid, 1'b0);
            end
            step();
        end
        check32("tp_queue_drained", exp_q.size(), 32'd0);

        // Held S2 picks up a writeback; stalled S1 re-reads across the write
        op_ready = 1'b0;
        drive_req(5'd5, 5'd9, 4'd7);
        check1("stall_req0_ready", req_ready, 1'b1);
        step();
        drive_req(5'd9, 5'd0, 4'd8);
        check1("stall_req1_ready", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        check1("stall_op_valid", op_valid, 1'b1);
        check32("stall_rs2_before", op_rs2_val, 32'h9);
        check1("stall_req_ready_low", req_ready, 1'b0);
        wb_we = 1'b1; wb_rd = 5'd9; wb_wd = 32'h55;
        step();
        wb_we = 1'b0;
        check1("stall_still_valid", op_valid, 1'b1);
        check32("stall_rs1_held", op_rs1_val, 32'h11);
        check32("stall_rs2_fwd", op_rs2_val, 32'h55);
        step();
        op_ready = 1'b1;
        check32("stall_tag_held", {28'd0, op_tag}, 32'd7);
        check32("stall_rs2_release", op_rs2_val, 32'h55);
        step();
        check1("stall_next_valid", op_valid, 1'b1);
        check32("stall_next_tag", {28'd0, op_tag}, 32'd8);
        check32("stall_next_rs1", op_rs1_val, 32'h55);
        check32("stall_next_rs2", op_rs2_val, 32'h0);
        step();
        check1("stall_drained", op_valid, 1'b0);

        // Reset with both slots occupied drops everything
        op_ready = 1'b0;
        drive_req(5'd5, 5'd6, 4'd1);
        step();
        drive_req(5'd6, 5'd5, 4'd2);
        step();
        req_valid = 1'b0;
        check1("rst_mid_full", op_valid, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        op_ready = 1'b1;
        check1("rst_mid_op_valid", op_valid, 1'b0);
        check1("rst_mid_req_ready", req_ready, 1'b1);
        check32("rst_mid_rs1_val", op_rs1_val, 32'h0);
        check32("rst_mid_tag", {28'd0, op_tag}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check1("rst_mid_no_output", op_valid, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
